pipe_io_responder: RTL and testbench

//  Memory-mapped I/O target answering the pipelined CPU's MEM-stage data bus (store strobe, ALU address, store data).

---
 rtl/pipe_io_responder.sv | 201 ++++++++++++++++++++
 tb/tb_pipe_io_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_io_responder.sv
// Memory-mapped I/O target on the pipelined CPU's MEM-stage data bus: LED, switch, timer,
// status registers and a byte TX FIFO drained over valid/ready. Optional irq output: IO_TIMER_IRQ_EN.
module pipe_io_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH = 4,
    parameter int          SW_WIDTH   = 16,
    parameter int          LED_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [31:0]          addr,
    input  logic                 wmem,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 hit,
    input  logic [SW_WIDTH-1:0]  sw,
    output logic [LED_WIDTH-1:0] led,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef IO_TIMER_IRQ_EN
    ,
    output logic                 irq
`endif
);

    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    localparam logic [5:0] OFF_LED    = 6'h00;
    localparam logic [5:0] OFF_SW     = 6'h01;
    localparam logic [5:0] OFF_TCOUNT = 6'h02;
    localparam logic [5:0] OFF_TCMP   = 6'h03;
    localparam logic [5:0] OFF_STATUS = 6'h04;
    localparam logic [5:0] OFF_TXDATA = 6'h05;

    logic [5:0]          woff;
    logic                wr;
    logic                wr_led;
    logic                wr_tcount;
    logic                wr_tcmp;
    logic                wr_status;
    logic                push_req;

    logic [SW_WIDTH-1:0] sw_q1;
    logic [SW_WIDTH-1:0] sw_q2;

    logic [31:0]         tcount;
    logic [31:0]         tcmp;
    logic                match;
    logic                match_set;

    logic [7:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [4:0]          count;
    logic                overflow;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;

    logic                irq_en_bit;
    logic [31:0]         status_word;

    // Byte lane bits are not decoded; registers are word-wide.
    logic                unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    assign hit       = (addr[31:8] == BASE_ADDR[31:8]);
    assign woff      = addr[7:2];
    assign wr        = wmem & hit;
    assign wr_led    = wr & (woff == OFF_LED);
    assign wr_tcount = wr & (woff == OFF_TCOUNT);
    assign wr_tcmp   = wr & (woff == OFF_TCMP);
    assign wr_status = wr & (woff == OFF_STATUS);
    assign push_req  = wr & (woff == OFF_TXDATA);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            led <= '0;
        end else if (wr_led) begin
            led <= wdata[LED_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_q1 <= '0;
            sw_q2 <= '0;
        end else begin
            sw_q1 <= sw;
            sw_q2 <= sw_q1;
        end
    end

    // The compare always sees the pre-write count; a software write only overrides the next value.
    assign match_set = (tcount == tcmp);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tcount <= '0;
            tcmp   <= '1;
            match  <= 1'b0;
        end else begin
            if (wr_tcount) begin
                tcount <= wdata;
            end else if (match_set) begin
                tcount <= '0;
            end else begin
                tcount <= tcount + 32'd1;
            end
            if (wr_tcmp) begin
                tcmp <= wdata;
            end
            if (match_set) begin
                match <= 1'b1;
            end else if (wr_status && wdata[0]) begin
                match <= 1'b0;
            end
        end
    end

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == 5'd0);
    assign pop        = ~fifo_empty & out_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign push       = push_req & (~fifo_full | pop);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (push_req && !push) begin
                overflow <= 1'b1;
            end else if (wr_status && wdata[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    assign out_valid = ~fifo_empty;
    assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

`ifdef IO_TIMER_IRQ_EN
    logic irq_en;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_status) begin
                irq_en <= wdata[9];
            end
            irq <= match & irq_en;
        end
    end

    assign irq_en_bit = irq_en;
`else
    assign irq_en_bit = 1'b0;
`endif

    assign status_word = {22'd0, irq_en_bit, count, overflow, fifo_empty, fifo_full, match};

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (woff)
                OFF_LED:    rdata = 32'(led);
                OFF_SW:     rdata = 32'(sw_q2);
                OFF_TCOUNT: rdata = tcount;
                OFF_TCMP:   rdata = tcmp;
                OFF_STATUS: rdata = status_word;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_io_responder.sv
// Directed and randomized bench for pipe_io_responder against a queue-based register-map model.
module tb_pipe_io_responder;

    localparam logic [31:0] A_LED    = 32'hFFFF_FF00;
    localparam logic [31:0] A_SW     = 32'hFFFF_FF04;
    localparam logic [31:0] A_TCOUNT = 32'hFFFF_FF08;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_FF0C;
    localparam logic [31:0] A_STATUS = 32'hFFFF_FF10;
    localparam logic [31:0] A_TX     = 32'hFFFF_FF14;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] addr;
    logic        wmem;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic [15:0] sw;
    logic [15:0] led;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef IO_TIMER_IRQ_EN
    logic        irq;
`endif

    pipe_io_responder dut (
        .clock(clock), .resetn(resetn), .addr(addr), .wmem(wmem), .wdata(wdata),
        .rdata(rdata), .hit(hit), .sw(sw), .led(led), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef IO_TIMER_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [15:0] m_led;
    logic [15:0] m_sw1, m_sw2;
    logic [31:0] m_tcount, m_tcmp;
    logic        m_match, m_ovf, m_irq_en, m_irq;
    logic [7:0]  q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_led = '0; m_sw1 = '0; m_sw2 = '0;
        m_tcount = '0; m_tcmp = 32'hFFFF_FFFF;
        m_match = 1'b0; m_ovf = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0;
        q.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int n;
        n = q.size();
        if (a[31:8] != 24'hFFFFFF) return 32'h0;
        case (int'(a[7:2]))
            0: return {16'h0, m_led};
            1: return {16'h0, m_sw2};
            2: return m_tcount;
            3: return m_tcmp;
            4: return {22'd0, m_irq_en, 5'(n), m_ovf, (n == 0), (n == 4), m_match};
            default: return 32'h0;
        endcase
    endfunction

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        addr = a; wmem = 1'b0;
        #1;
        v = rdata;
    endtask

    // One bus cycle: check outputs against the model mid-cycle, clock, then advance the model.
    task automatic apply(input logic [31:0] a, input logic w, input logic [31:0] d);
        logic        wr, pop, mset, ovf_set, push;
        int          off;
        logic [31:0] n_tcount, n_tcmp;
        logic        n_match, n_ovf, n_irq_en, n_irq;
        logic [15:0] n_led, sw_at;
        addr = a; wmem = w; wdata = d;
        #3;
        check("rdata", rdata, model_read(a));
        check("hit", hit, a[31:8] == 24'hFFFFFF);
        check("out_valid", out_valid, q.size() != 0);
        check("out_data", out_data, (q.size() != 0) ? q[0] : 8'h00);
        check("led", led, m_led);
`ifdef IO_TIMER_IRQ_EN
        check("irq", irq, m_irq);
`endif
        wr   = w && (a[31:8] == 24'hFFFFFF);
        off  = int'(a[7:2]);
        pop  = (q.size() != 0) && out_ready;
        mset = (m_tcount == m_tcmp);
        push = wr && off == 5 && (q.size() < 4 || pop);
        ovf_set  = wr && off == 5 && !push;
        n_tcount = (wr && off == 2) ? d : (mset ? 32'h0 : m_tcount + 32'd1);
        n_tcmp   = (wr && off == 3) ? d : m_tcmp;
        n_match  = mset ? 1'b1 : ((wr && off == 4 && d[0]) ? 1'b0 : m_match);
        n_ovf    = ovf_set ? 1'b1 : ((wr && off == 4 && d[3]) ? 1'b0 : m_ovf);
        n_led    = (wr && off == 0) ? d[15:0] : m_led;
`ifdef IO_TIMER_IRQ_EN
        n_irq_en = (wr && off == 4) ? d[9] : m_irq_en;
        n_irq    = m_match & m_irq_en;
`else
        n_irq_en = 1'b0;
        n_irq    = 1'b0;
`endif
        sw_at = sw;
        @(posedge clock);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(d[7:0]);
        m_tcount = n_tcount; m_tcmp = n_tcmp; m_match = n_match; m_ovf = n_ovf;
        m_led = n_led; m_irq_en = n_irq_en; m_irq = n_irq;
        m_sw2 = m_sw1; m_sw1 = sw_at;
    endtask

    logic [31:0] v;
    logic [7:0]  exp3 [4];
    logic [7:0]  exp4 [4];

    initial begin
        exp3 = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp4 = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
        addr = '0; wmem = 1'b0; wdata = '0; sw = '0; out_ready = 1'b0; resetn = 1'b0;
        model_reset();
        #12;
        // 1: reset state
        peek(A_LED, v);    check("t1_led", v, 32'h0);
        peek(A_TCMP, v);   check("t1_tcmp", v, 32'hFFFF_FFFF);
        peek(A_STATUS, v); check("t1_status", v, 32'h0000_0004);
        peek(A_TCOUNT, v); check("t1_tcount", v, 32'h0);
        check("t1_out_valid", out_valid, 1'b0);
        check("t1_out_data", out_data, 8'h00);
        @(posedge clock); #1;
        resetn = 1'b1;

        // 2: timer match and wrap
        apply(A_TCMP, 1'b1, 32'd5);
        apply(A_TCOUNT, 1'b1, 32'd0);
        repeat (5) apply(A_STATUS, 1'b0, 32'h0);
        peek(A_STATUS, v); check("t2_no_match_yet", v[0], 1'b0);
        apply(A_STATUS, 1'b0, 32'h0);
        peek(A_STATUS, v); check("t2_match", v[0], 1'b1);
        peek(A_TCOUNT, v); check("t2_wrap_tcount", v, 32'h0);
        apply(A_STATUS, 1'b1, 32'h1);
        peek(A_STATUS, v); check("t2_w1c_match", v[0], 1'b0);

        // 3: overflow with sink stalled, then in-order drain
        out_ready = 1'b0;
        apply(A_TX, 1'b1, 32'h11);
        apply(A_TX, 1'b1, 32'h22);
        apply(A_TX, 1'b1, 32'h33);
        apply(A_TX, 1'b1, 32'h44);
        apply(A_TX, 1'b1, 32'h55);
        peek(A_STATUS, v); check("t3_status", v[8:1], 8'h25);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_byte", out_data, exp3[i]);
            apply(A_STATUS, 1'b0, 32'h0);
        end
        check("t3_drained", out_valid, 1'b0);

        // 4: push into a full FIFO while it pops
        out_ready = 1'b0;
        apply(A_STATUS, 1'b1, 32'h8);
        apply(A_TX, 1'b1, 32'hA1);
        apply(A_TX, 1'b1, 32'hA2);
        apply(A_TX, 1'b1, 32'hA3);
        apply(A_TX, 1'b1, 32'hA4);
        peek(A_STATUS, v); check("t4_full", v[8:1], 8'h21);
        out_ready = 1'b1;
        check("t4_head", out_data, 8'hA1);
        apply(A_TX, 1'b1, 32'h66);
        peek(A_STATUS, v); check("t4_still_full", v[8:1], 8'h21);
        for (int i = 0; i < 4; i++) begin
            check("t4_byte", out_data, exp4[i]);
            apply(A_STATUS, 1'b0, 32'h0);
        end
        check("t4_drained", out_valid, 1'b0);

        // 5: switch synchroniser latency, read-only
        out_ready = 1'b0;
        sw = 16'hA5A5;
        apply(A_SW, 1'b0, 32'h0);
        peek(A_SW, v); check("t5_sw_1cyc", v, 32'h0);
        apply(A_SW, 1'b0, 32'h0);
        peek(A_SW, v); check("t5_sw_2cyc", v, 32'h0000_A5A5);
        apply(A_SW, 1'b1, 32'h1234);
        peek(A_SW, v); check("t5_sw_ro", v, 32'h0000_A5A5);

`ifdef IO_TIMER_IRQ_EN
        // 6: irq follows match by one cycle
        apply(A_TCMP, 1'b1, 32'd1000);
        apply(A_STATUS, 1'b1, 32'h201);
        apply(A_TCOUNT, 1'b1, 32'd0);
        apply(A_TCMP, 1'b1, 32'd2);
        apply(A_STATUS, 1'b0, 32'h0);
        peek(A_STATUS, v); check("t6_no_match", v[0], 1'b0);
        apply(A_STATUS, 1'b0, 32'h0);
        peek(A_STATUS, v); check("t6_match", v[0], 1'b1);
        check("t6_irq_low", irq, 1'b0);
        apply(A_STATUS, 1'b0, 32'h0);
        check("t6_irq_high", irq, 1'b1);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, d;
            logic        w;
            logic [5:0]  off;
            off = ($urandom_range(0, 3) == 0) ? 6'd5 : 6'($urandom_range(0, 8));
            if ($urandom_range(0, 9) == 0) a = {24'h001234, 8'($urandom)};
            else a = {24'hFFFFFF, off, 2'($urandom_range(0, 3))};
            w = ($urandom_range(0, 1) == 1);
            d = $urandom;
            if (a[7:2] == 6'd2 || a[7:2] == 6'd3) d = $urandom_range(0, 30);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
            apply(a, w, d);
        end

        // asynchronous reset mid-operation
        out_ready = 1'b0;
        apply(A_LED, 1'b1, 32'h5A5A);
        apply(A_TX, 1'b1, 32'h77);
        apply(A_TX, 1'b1, 32'h88);
        check("rst_pre_valid", out_valid, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 1'b0);
        check("rst_async_data", out_data, 8'h00);
        check("rst_led", led, 16'h0);
        model_reset();
        peek(A_STATUS, v); check("rst_status", v, 32'h0000_0004);
        @(posedge clock); #1;
        resetn = 1'b1;
        sw = 16'h0;
        out_ready = 1'b1;
        repeat (4) apply(A_TX, 1'b1, 32'($urandom_range(0, 255)));
        repeat (3) apply(A_STATUS, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
